// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell with a registered carry,
// LSB first, start/busy/done handshake; result and carry-out held until the next run completes.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nx;
   logic [CW-1:0]    cnt;
   logic             carry, s, c, last, accept;

   assign s      = a_sr[0] ^ b_sr[0] ^ carry;
   assign c      = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign last   = cnt == CW'(WIDTH - 1);
   assign accept = start && state != RUN;
   assign busy   = state == RUN;
   assign done   = state == DONE;

   always_comb begin
      r_nx = r_sr >> 1;
      r_nx[WIDTH-1] = s;
      state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nx;
            carry <= c;
            cnt   <= cnt + 1'b1;
            // r_nx already holds this edge's sum bit, so it is the complete result
            if (last) begin
               sum  <= r_nx;
               cout <= c;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH=8 and WIDTH=1)
// against a plain-arithmetic reference a+b+cin.
module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0, sum;
   logic       busy, done, cout;
   logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
   logic       busy1, done1, sum1, cout1;
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
      return {1'b0, x} + {1'b0, y} + {8'd0, ci};
   endfunction

   // one pulsed start on the WIDTH=8 instance; lat counts cycles from accept to done (-1 on timeout)
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                      output logic [8:0] got, output int lat, output int nbusy);
      @(negedge clk);
      start = 1'b1; a = x; b = y; cin = ci;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
      lat = 1; nbusy = 0;
      while (!done && lat < 40) begin
         nbusy += int'(busy);
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      got = {cout, sum};
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
      end
      checks++;
      if ({busy1, done1, sum1, cout1} !== 4'd0) begin
         errors++;
         $display("FAIL reset_w1: busy=%b done=%b sum=%b cout=%b, required all 0", busy1, done1, sum1, cout1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [8:0] got;
      int lat, nb;
      op8(8'h5A, 8'h33, 1'b0, got, lat, nb);
      checks++;
      if (got !== 9'h08D) begin
         errors++;
         $display("FAIL basic_sum: got cout/sum=%h, required 08d", got);
      end
      checks++;
      if (lat !== 9 || nb !== 8) begin
         errors++;
         $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, required 9 and 8", lat, nb);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h8D) begin
         errors++;
         $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0 0 8d", done, busy, sum);
      end
   endtask

   task automatic test_ripple;
      logic [8:0] got;
      int lat, nb;
      op8(8'hFF, 8'h01, 1'b0, got, lat, nb);
      checks++;
      if (got !== 9'h100) begin
         errors++;
         $display("FAIL ripple_ff_01: got %h, required 100", got);
      end
      op8(8'hFF, 8'hFF, 1'b1, got, lat, nb);
      checks++;
      if (got !== 9'h1FF) begin
         errors++;
         $display("FAIL ripple_ff_ff_1: got %h, required 1ff", got);
      end
   endtask

   task automatic test_random;
      logic [8:0] got;
      logic [7:0] x, y;
      logic ci;
      int lat, nb;
      for (int i = 0; i < 20; i++) begin
         x = $urandom; y = $urandom; ci = $urandom;
         op8(x, y, ci, got, lat, nb);
         checks++;
         if (got !== model(x, y, ci) || lat !== 9 || nb !== 8) begin
            errors++;
            $display("FAIL random_%0d: %h+%h+%b got %h lat=%0d busy=%0d, required %h lat=9 busy=8",
                     i, x, y, ci, got, lat, nb, model(x, y, ci));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_start_while_busy;
      int n;
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 4;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 9 || sum !== 8'h30 || cout !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore: latency=%0d sum=%h cout=%b, required 9 30 0", n, sum, cout);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h30) begin
            errors++;
            $display("FAIL busy_no_queue: done=%b busy=%b sum=%h, required 0 0 30", done, busy, sum);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] xs[5], ys[5];
      logic cs[5];
      logic [8:0] prev, exp;
      int n;
      for (int k = 0; k < 5; k++) begin
         xs[k] = $urandom; ys[k] = $urandom; cs[k] = $urandom;
      end
      prev = {cout, sum};
      @(negedge clk);
      start = 1'b1; a = xs[0]; b = ys[0]; cin = cs[0];
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (!done) begin
               a = $urandom; b = $urandom; cin = $urandom;
            end
            checks++;
            if (busy !== !done || (!done && {cout, sum} !== prev)) begin
               errors++;
               $display("FAIL b2b_run_%0d: busy=%b done=%b result=%h, required busy=!done and held %h",
                        k, busy, done, {cout, sum}, prev);
            end
         end while (!done && n < 40);
         exp = model(xs[k], ys[k], cs[k]);
         checks++;
         if (n !== 9 || {cout, sum} !== exp) begin
            errors++;
            $display("FAIL b2b_result_%0d: period=%0d result=%h, required 9 %h", k, n, {cout, sum}, exp);
         end
         prev = exp;
         if (k < 4) begin
            a = xs[k+1]; b = ys[k+1]; cin = cs[k+1];
         end else start = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      logic [8:0] got;
      int lat, nb;
      @(negedge clk);
      start = 1'b1; a = 8'hC3; b = 8'h5E; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
         errors++;
         $display("FAIL reset_async: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h01, 8'h01, 1'b1, got, lat, nb);
      checks++;
      if (got !== 9'h003 || lat !== 9) begin
         errors++;
         $display("FAIL reset_recover: got %h lat=%0d, required 003 lat=9", got, lat);
      end
   endtask

   task automatic test_width1;
      logic [2:0] v;
      int n;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         @(negedge clk);
         start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
         @(negedge clk);
         start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
         n = 1;
         while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n !== 2 || {cout1, sum1} !== 2'(v[2] + v[1] + v[0])) begin
            errors++;
            $display("FAIL w1_%0d: latency=%0d cout/sum=%b%b, required 2 %b",
                     i, n, cout1, sum1, 2'(v[2] + v[1] + v[0]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_start_while_busy();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_width1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single 1-bit full-adder cell with a registered carry.
- Latches two operands and feeds the cell one bit pair per clock, LSB first.
- Feeds the cell's sum output back into a result shift register and its carry output back into the carry flop.
- Trades N cycles of latency for one adder cell; sits between operand producers and any consumer that accepts a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cin  input  1  carry-in; sampled only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out of the addition.

Behaviour:
- Reset: rst_n low forces, asynchronously:
  - state to IDLE;
  - busy, done, sum, cout to 0;
  - operand shift registers, result shift register, carry flop and bit counter to 0.
- States:
  - IDLE: waiting for start.
  - RUN: shifting bits through the cell.
  - DONE: one-cycle result-valid state.
- Derived outputs: busy = (state == RUN); done = (state == DONE).
- Start acceptance:
  - Accepted when start=1 at a rising edge with state IDLE or DONE.
  - On acceptance: load a and b into the operand shift registers, carry <= cin, counter <= 0, state <= RUN.
- Start is ignored in RUN; no queuing, and operands are not resampled.
- RUN, each edge:
  - The cell computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
  - Result shift register shifts right with s entering at bit WIDTH-1.
  - a_sr and b_sr shift right, zero-filled.
  - carry <= c; counter <= counter + 1.
- RUN exit: on the edge where counter == WIDTH-1:
  - sum <= final result shift register contents, including this edge's s;
  - cout <= c;
  - state <= DONE.
- DONE:
  - Lasts exactly one cycle.
  - Next state is RUN if start=1 (back-to-back operation), else IDLE.
- Hold: sum and cout update only on the RUN-to-DONE edge. They hold their values through IDLE and through the next RUN until that run completes.
- Latency:
  - Start accepted at edge E0; bits 0..WIDTH-1 processed at edges E1..EWIDTH.
  - done is high for the cycle following edge EWIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- WIDTH=1: a single RUN cycle, then DONE.
- Counter width: clog2(WIDTH) bits, minimum 1.
- Reset mid-run: the operation is aborted with no partial result; outputs follow reset values; the next start after rst_n deasserts behaves normally.
- Operand inputs may change freely after the accepting edge without affecting the result.

Test Plan:
- Basic add (WIDTH=8): a=0x5A, b=0x33, cin=0, start pulsed one cycle -> busy high for 8 cycles, done pulse 9 cycles after start edge, sum=0x8D, cout=0.
- Full ripple carry (WIDTH=8): a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy: start a=0x10, b=0x20; at RUN cycle 3 pulse start with a=0xAA, b=0x55 -> ignored; done shows sum=0x30, cout=0; sum holds 0x30 afterwards.
- Back-to-back: hold start=1 continuously while presenting a new operand pair at each accepted edge -> done pulses every 9 cycles; each result matches its own operands; busy is low only during DONE cycles.
- Reset mid-run: assert rst_n=0 at RUN cycle 4 -> busy, done, sum, cout read 0 immediately (asynchronous). After release, a=0x01, b=0x01, cin=1 -> sum=0x03, cout=0.
- Exhaustive (WIDTH=1): all 8 combinations of {a, b, cin} -> {cout, sum} equals a+b+cin; done 2 cycles after each start edge.
